// File: rtl/scan_decoder_if.sv
// rtl/scan_decoder_if.sv - control inputs and digit-enable outputs of scan_decoder
interface scan_decoder_if #(
  parameter int SEL_W = 3
);
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [2**SEL_W-1:0]   o;
  logic [SEL_W-1:0]      idx;
  logic                  step;

  modport master (output en, mode, sel, input o, idx, step);
  modport slave  (input en, mode, sel, output o, idx, step);
endinterface

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N one-hot decoder with multiplexed-display scanner
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int NUM        = 8,
  parameter int DIV        = 50000,
  parameter int GAP        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic           clk,
  input  logic           rst,
  scan_decoder_if.slave  bus
);
  localparam int OW    = 2**SEL_W;
  localparam int MAXC  = (DIV > GAP) ? DIV : GAP;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [SEL_W:0]   NUM_LIM    = (SEL_W+1)'(NUM);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(NUM - 1);
  localparam logic [OW-1:0]    O_INACTIVE = (ACTIVE_LOW != 0) ? {OW{1'b1}} : '0;

  typedef enum logic [1:0] {IDLE, DIRECT, SHOW, BLANK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic             r_step, w_step_nxt;
  logic [OW-1:0]    r_o, w_oh_nxt;
  logic [SEL_W-1:0] w_start_idx, w_adv_idx;
  logic             w_sel_ok;

  function automatic logic [OW-1:0] onehot(input logic [SEL_W-1:0] k);
    logic [OW-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // A scan never starts on a digit outside the populated range
  assign w_start_idx = ({1'b0, r_idx} < NUM_LIM) ? r_idx : '0;
  assign w_adv_idx   = (r_idx == IDX_LAST) ? '0 : r_idx + SEL_W'(1);
  assign w_sel_ok    = ({1'b0, bus.sel} < NUM_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_step_nxt  = 1'b0;
    w_oh_nxt    = '0;
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (!bus.mode) begin
      w_state_nxt = DIRECT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = bus.sel;
      w_oh_nxt    = w_sel_ok ? onehot(bus.sel) : '0;
    end else begin
      case (r_state)
        IDLE, DIRECT: begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
          w_idx_nxt   = w_start_idx;
          w_oh_nxt    = onehot(w_start_idx);
        end
        SHOW: begin
          if (r_cnt == DIV_LAST) begin
            w_cnt_nxt = '0;
            if (GAP > 0) begin
              w_state_nxt = BLANK;
            end else begin
              w_idx_nxt  = w_adv_idx;
              w_oh_nxt   = onehot(w_adv_idx);
              w_step_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_oh_nxt  = onehot(r_idx);
          end
        end
        BLANK: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
            w_idx_nxt   = w_adv_idx;
            w_oh_nxt    = onehot(w_adv_idx);
            w_step_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_step  <= 1'b0;
      r_o     <= O_INACTIVE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_step  <= w_step_nxt;
      r_o     <= (ACTIVE_LOW != 0) ? ~w_oh_nxt : w_oh_nxt;
    end
  end

  assign bus.o    = r_o;
  assign bus.idx  = r_idx;
  assign bus.step = r_step;
endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - randomized scoreboard bench for scan_decoder (default, GAP=0, ACTIVE_LOW=1)
module tb_scan_decoder;
  localparam int SEL_W = 3;
  localparam int NUM   = 6;
  localparam int DIV   = 4;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] idx;
    logic       step;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(SEL_W)) bus_a ();
  scan_decoder_if #(.SEL_W(SEL_W)) bus_g ();
  scan_decoder_if #(.SEL_W(SEL_W)) bus_l ();

  scan_decoder #(.SEL_W(SEL_W), .NUM(NUM), .DIV(DIV), .GAP(2), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  scan_decoder #(.SEL_W(SEL_W), .NUM(NUM), .DIV(DIV), .GAP(0), .ACTIVE_LOW(0)) dut_g (
    .clk(clk), .rst(rst), .bus(bus_g.slave));
  scan_decoder #(.SEL_W(SEL_W), .NUM(NUM), .DIV(DIV), .GAP(2), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .bus(bus_l.slave));

  int errors = 0;
  int checks = 0;
  exp_t qa[$];
  exp_t qg[$];
  exp_t ql[$];

  // Reference: position within a DIV+GAP digit period and the digit number
  int m_run[3];
  int m_pos[3];
  int m_idx[3];
  int gap_of[3] = '{2, 0, 2};
  int low_of[3] = '{0, 0, 1};

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got o=%h idx=%0d step=%b, want o=%h idx=%0d step=%b",
               name, $time, act.o, act.idx, act.step, exp.o, exp.idx, exp.step);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0;
      m_pos[k] = 0;
      m_idx[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit en, input bit mode, input int sel, output exp_t e);
    logic [7:0] oh;
    logic       st;
    oh = 8'h00;
    st = 1'b0;
    if (!en) begin
      m_run[k] = 0;
    end else if (!mode) begin
      m_run[k] = 0;
      m_idx[k] = sel;
      if (sel < NUM) oh = 8'(1 << sel);
    end else begin
      if (m_run[k] == 0) begin
        m_run[k] = 1;
        m_pos[k] = 0;
        if (m_idx[k] >= NUM) m_idx[k] = 0;
      end else begin
        m_pos[k]++;
        if (m_pos[k] == DIV + gap_of[k]) begin
          m_pos[k] = 0;
          m_idx[k] = (m_idx[k] + 1) % NUM;
          st = 1'b1;
        end
      end
      if (m_pos[k] < DIV) oh = 8'(1 << m_idx[k]);
    end
    e.o    = (low_of[k] != 0) ? ~oh : oh;
    e.idx  = 3'(m_idx[k]);
    e.step = st;
  endtask

  task automatic cycle(input bit en, input bit mode, input int sel);
    exp_t ea, eg, el;
    bus_a.en = en; bus_a.mode = mode; bus_a.sel = 3'(sel);
    bus_g.en = en; bus_g.mode = mode; bus_g.sel = 3'(sel);
    bus_l.en = en; bus_l.mode = mode; bus_l.sel = 3'(sel);
    model_edge(0, en, mode, sel, ea);
    model_edge(1, en, mode, sel, eg);
    model_edge(2, en, mode, sel, el);
    @(posedge clk);
    qa.push_back(ea);
    qg.push_back(eg);
    ql.push_back(el);
    #1;
  endtask

  // Reset is raised between edges and checked before any clock edge
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_a", {bus_a.o, bus_a.idx, bus_a.step}, {8'h00, 3'd0, 1'b0});
    check("async_rst_g", {bus_g.o, bus_g.idx, bus_g.step}, {8'h00, 3'd0, 1'b0});
    check("async_rst_l", {bus_l.o, bus_l.idx, bus_l.step}, {8'hFF, 3'd0, 1'b0});
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (qa.size() > 0) check("dut_a", {bus_a.o, bus_a.idx, bus_a.step}, qa.pop_front());
      if (qg.size() > 0) check("dut_g", {bus_g.o, bus_g.idx, bus_g.step}, qg.pop_front());
      if (ql.size() > 0) check("dut_l", {bus_l.o, bus_l.idx, bus_l.step}, ql.pop_front());
    end
  end

  initial begin
    bit r_en;
    bit r_mode;
    rst = 1'b0;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.sel = '0;
    bus_g.en = 1'b0; bus_g.mode = 1'b0; bus_g.sel = '0;
    bus_l.en = 1'b0; bus_l.mode = 1'b0; bus_l.sel = '0;
    #1;
    rst = 1'b1;
    #1;
    check("init_rst_a", {bus_a.o, bus_a.idx, bus_a.step}, {8'h00, 3'd0, 1'b0});
    check("init_rst_l", {bus_l.o, bus_l.idx, bus_l.step}, {8'hFF, 3'd0, 1'b0});
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int s = 0; s < 8; s++) cycle(1'b1, 1'b0, s);

    async_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 0);

    async_reset();
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 0);

    async_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 0);
    async_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b0, 5);
    cycle(1'b1, 1'b0, 5);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 5);

    r_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r_en = ($urandom_range(7, 0) != 0);
      if ($urandom_range(15, 0) == 0) r_mode = !r_mode;
      if ($urandom_range(99, 0) == 0) async_reset();
      cycle(r_en, r_mode, int'($urandom_range(7, 0)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (qa.size() + qg.size() + ql.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", qa.size() + qg.size() + ql.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
